mgt_01_i_writeback_unit: RTL and testbench



---
 rtl/mgt_01_wb_pkg.sv | 25 ++
 rtl/mgt_01_rr_multi_grant.sv | 60 ++++++
 rtl/mgt_01_i_writeback_unit.sv | 161 ++++++++++++++++
 tb/tb_mgt_01_i_writeback_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mgt_01_wb_pkg.sv
// Shared types and constants for the integer write-back unit.
package mgt_01_wb_pkg;

  localparam int unsigned MGT_01_NUM_SRC = 4;

  localparam int unsigned SRC_ALU = 0;
  localparam int unsigned SRC_MUL = 1;
  localparam int unsigned SRC_DIV = 2;
  localparam int unsigned SRC_LSU = 3;

  typedef logic [31:0] data_bus_t;

  typedef enum logic [4:0] {
    X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,
    X8,  X9,  X10, X11, X12, X13, X14, X15,
    X16, X17, X18, X19, X20, X21, X22, X23,
    X24, X25, X26, X27, X28, X29, X30, X31
  } i_register_e;

  typedef struct packed {
    i_register_e addr;
    data_bus_t   data;
  } wb_req_t;

endpackage

// File: rtl/mgt_01_rr_multi_grant.sv
// Round-robin multi-grant arbiter: starting at i_ptr, grants up to
// WRITE_PORTS requesters, skipping any whose conflict row hits an earlier
// grant. Grant k is reported one-hot in slice k of o_port_grant.
module mgt_01_rr_multi_grant #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned WRITE_PORTS = 2
) (
  input  logic [NUM_SRC-1:0]             i_req,
  input  logic [$clog2(NUM_SRC)-1:0]     i_ptr,
  input  logic [NUM_SRC*NUM_SRC-1:0]     i_conflict,
  output logic [NUM_SRC-1:0]             o_grant,
  output logic [WRITE_PORTS*NUM_SRC-1:0] o_port_grant,
  output logic [WRITE_PORTS-1:0]         o_port_vld,
  output logic [$clog2(NUM_SRC)-1:0]     o_next_ptr
);

  localparam int unsigned PTR_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]     w_src_oh;
  logic [NUM_SRC-1:0]     w_last_oh;
  logic [NUM_SRC-1:0]     w_conf;
  logic [NUM_SRC-1:0]     w_rot;
  logic [WRITE_PORTS-1:0] w_port_oh;

  // Walk sources in rotated order with one-hot cursors for source and port
  always_comb begin
    o_grant      = '0;
    o_port_grant = '0;
    o_port_vld   = '0;
    o_next_ptr   = i_ptr;
    w_src_oh     = NUM_SRC'(1) << i_ptr;
    w_port_oh    = WRITE_PORTS'(1);
    w_last_oh    = '0;
    w_conf       = '0;
    w_rot        = '0;
    for (int unsigned off = 0; off < NUM_SRC; off++) begin
      w_conf = '0;
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
        if (w_src_oh[s]) w_conf = i_conflict[s*NUM_SRC +: NUM_SRC];
      end
      if ((|(i_req & w_src_oh)) && (|w_port_oh) && !(|(w_conf & o_grant))) begin
        o_grant    = o_grant | w_src_oh;
        o_port_vld = o_port_vld | w_port_oh;
        for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
          if (w_port_oh[k]) o_port_grant[k*NUM_SRC +: NUM_SRC] = w_src_oh;
        end
        w_port_oh = w_port_oh << 1;
        w_last_oh = w_src_oh;
      end
      w_src_oh = {w_src_oh[NUM_SRC-2:0], w_src_oh[NUM_SRC-1]};
    end
    if (|o_grant) begin
      w_rot = {w_last_oh[NUM_SRC-2:0], w_last_oh[NUM_SRC-1]};
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
        if (w_rot[s]) o_next_ptr = PTR_W'(s);
      end
    end
  end

endmodule

// File: rtl/mgt_01_i_writeback_unit.sv
// Integer register-file write-back unit: one holding buffer per source,
// round-robin multi-grant retirement into registered write ports.
// Optional forwarding lookup ports are enabled with MGT_01_WB_FWD_EN.
module mgt_01_i_writeback_unit
  import mgt_01_wb_pkg::*;
#(
  parameter int unsigned NUM_SRC     = MGT_01_NUM_SRC,
  parameter int unsigned WRITE_PORTS = 2
`ifdef MGT_01_WB_FWD_EN
  , parameter int unsigned FWD_PORTS = 2
`endif
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clk_en_i,
  input  logic [NUM_SRC-1:0]        src_valid_i,
  output logic [NUM_SRC-1:0]        src_ready_o,
  input  logic [NUM_SRC*5-1:0]      src_addr_i,
  input  logic [NUM_SRC*32-1:0]     src_data_i,
  output logic [WRITE_PORTS-1:0]    we_o,
  output logic [WRITE_PORTS*5-1:0]  wr_iaddr_o,
  output logic [WRITE_PORTS*32-1:0] wr_idata_o,
  output logic                      busy_o
`ifdef MGT_01_WB_FWD_EN
  , input  logic [FWD_PORTS*5-1:0]  fwd_addr_i
  , output logic [FWD_PORTS-1:0]    fwd_hit_o
  , output logic [FWD_PORTS*32-1:0] fwd_data_o
`endif
);

  localparam int unsigned PTR_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]     r_pending;
  wb_req_t                r_req [NUM_SRC];
  logic [PTR_W-1:0]       r_rr_ptr;
  logic [WRITE_PORTS-1:0] r_we;
  i_register_e            r_waddr [WRITE_PORTS];
  data_bus_t              r_wdata [WRITE_PORTS];

  logic [NUM_SRC-1:0]             w_req;
  logic [NUM_SRC-1:0]             w_grant;
  logic [NUM_SRC*NUM_SRC-1:0]     w_conflict;
  logic [WRITE_PORTS*NUM_SRC-1:0] w_port_grant;
  logic [WRITE_PORTS-1:0]         w_port_vld;
  logic [PTR_W-1:0]               w_next_ptr;
  wb_req_t                        w_sel [WRITE_PORTS];

  assign w_req       = r_pending & {NUM_SRC{clk_en_i}};
  assign src_ready_o = {NUM_SRC{clk_en_i}} & (~r_pending | w_grant);
  assign busy_o      = (|r_pending) | (|r_we);
  assign we_o        = r_we;

  // Pairwise same-register conflicts between buffered entries (X0 never conflicts)
  always_comb begin
    w_conflict = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      for (int unsigned j = 0; j < NUM_SRC; j++) begin
        w_conflict[i*NUM_SRC+j] = (i != j) && (r_req[i].addr != X0) &&
                                  (r_req[i].addr == r_req[j].addr);
      end
    end
  end

  mgt_01_rr_multi_grant #(
    .NUM_SRC     (NUM_SRC),
    .WRITE_PORTS (WRITE_PORTS)
  ) u_arb (
    .i_req        (w_req),
    .i_ptr        (r_rr_ptr),
    .i_conflict   (w_conflict),
    .o_grant      (w_grant),
    .o_port_grant (w_port_grant),
    .o_port_vld   (w_port_vld),
    .o_next_ptr   (w_next_ptr)
  );

  // Route each port's granted buffer entry through a one-hot mux
  always_comb begin
    for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
      w_sel[k] = '0;
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
        if (w_port_grant[k*NUM_SRC+s]) w_sel[k] = r_req[s];
      end
    end
  end

  // Flatten registered write-port state onto the output buses
  always_comb begin
    wr_iaddr_o = '0;
    wr_idata_o = '0;
    for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
      wr_iaddr_o[k*5 +: 5]   = r_waddr[k];
      wr_idata_o[k*32 +: 32] = r_wdata[k];
    end
  end

  // Buffers, round-robin pointer and registered write ports
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending <= '0;
      r_rr_ptr  <= '0;
      r_we      <= '0;
      for (int unsigned s = 0; s < NUM_SRC; s++) r_req[s] <= '0;
      for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
        r_waddr[k] <= X0;
        r_wdata[k] <= '0;
      end
    end else if (clk_en_i) begin
      // An accept on a granted buffer replaces the departing entry
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
        if (src_valid_i[s] && src_ready_o[s]) begin
          r_pending[s]  <= 1'b1;
          r_req[s].addr <= i_register_e'(src_addr_i[s*5 +: 5]);
          r_req[s].data <= src_data_i[s*32 +: 32];
        end else if (w_grant[s]) begin
          r_pending[s] <= 1'b0;
        end
      end
      r_rr_ptr <= w_next_ptr;
      for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
        r_we[k] <= w_port_vld[k] && (w_sel[k].addr != X0);
        if (w_port_vld[k]) begin
          r_waddr[k] <= w_sel[k].addr;
          r_wdata[k] <= w_sel[k].data;
        end
      end
    end else begin
      r_we <= '0;
    end
  end

`ifdef MGT_01_WB_FWD_EN
  logic w_fwd_found;

  // Forwarding lookup: pending buffers (lowest source) beat live write ports (lowest port)
  always_comb begin
    fwd_hit_o   = '0;
    fwd_data_o  = '0;
    w_fwd_found = 1'b0;
    for (int unsigned f = 0; f < FWD_PORTS; f++) begin
      w_fwd_found = 1'b0;
      if (fwd_addr_i[f*5 +: 5] != 5'd0) begin
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
          if (!w_fwd_found && r_pending[s] && (r_req[s].addr == fwd_addr_i[f*5 +: 5])) begin
            w_fwd_found             = 1'b1;
            fwd_data_o[f*32 +: 32]  = r_req[s].data;
          end
        end
        for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
          if (!w_fwd_found && r_we[k] && (r_waddr[k] == fwd_addr_i[f*5 +: 5])) begin
            w_fwd_found             = 1'b1;
            fwd_data_o[f*32 +: 32]  = r_wdata[k];
          end
        end
      end
      fwd_hit_o[f] = w_fwd_found;
    end
  end
`endif

endmodule

// File: tb/tb_mgt_01_i_writeback_unit.sv
// Directed vector bench for mgt_01_i_writeback_unit (default build).
module tb_mgt_01_i_writeback_unit;

  typedef logic [3:0][4:0]  a4_t;
  typedef logic [3:0][31:0] d4_t;
  typedef logic [1:0][4:0]  a2_t;
  typedef logic [1:0][31:0] d2_t;

  typedef struct {
    logic       en;
    logic [3:0] valid;
    a4_t        addr;
    d4_t        data;
    logic [3:0] exp_ready;
    logic [1:0] exp_we;
    a2_t        exp_addr;
    d2_t        exp_data;
    logic       exp_busy;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  valid;
  a4_t         addr;
  d4_t         data;
  logic [3:0]  ready;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  mgt_01_i_writeback_unit #(
    .NUM_SRC     (4),
    .WRITE_PORTS (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clk_en_i    (en),
    .src_valid_i (valid),
    .src_ready_o (ready),
    .src_addr_i  (addr),
    .src_data_i  (data),
    .we_o        (we),
    .wr_iaddr_o  (waddr),
    .wr_idata_o  (wdata),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic e, input logic [3:0] vl, input a4_t a, input d4_t d,
                             input logic [3:0] rdy, input logic [1:0] w, input a2_t ea,
                             input d2_t ed, input logic b);
    vec_t r;
    r.en = e; r.valid = vl; r.addr = a; r.data = d;
    r.exp_ready = rdy; r.exp_we = w; r.exp_addr = ea; r.exp_data = ed; r.exp_busy = b;
    return r;
  endfunction

  localparam a4_t A4 = {5'd4, 5'd3, 5'd2, 5'd1};
  localparam d4_t DA = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
  localparam d4_t DB = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
  localparam d4_t DC = {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000};

  initial begin
    // Full load, distinct addresses x1..x4, starting from rr_ptr=0
    vecs.push_back(v(1, 4'b1111, A4, DA, 4'b1111, 2'b00, '0, '0, 1));
    vecs.push_back(v(1, 4'b1111, A4, DB, 4'b0011, 2'b11, {5'd2, 5'd1}, {32'hA000_0001, 32'hA000_0000}, 1));
    vecs.push_back(v(1, 4'b1111, A4, DC, 4'b1100, 2'b11, {5'd4, 5'd3}, {32'hA000_0003, 32'hA000_0002}, 1));
    vecs.push_back(v(1, 4'b0000, '0, '0, 4'b0011, 2'b11, {5'd2, 5'd1}, {32'hB000_0001, 32'hB000_0000}, 1));
    vecs.push_back(v(1, 4'b0000, '0, '0, 4'b1111, 2'b11, {5'd4, 5'd3}, {32'hC000_0003, 32'hC000_0002}, 1));
    vecs.push_back(v(1, 4'b0000, '0, '0, 4'b1111, 2'b00, '0, '0, 0));
    // Basic single write, rr_ptr=0
    vecs.push_back(v(1, 4'b0001, {15'd0, 5'd5}, {96'd0, 32'hDEAD_BEEF}, 4'b1111, 2'b00, '0, '0, 1));
    vecs.push_back(v(1, 4'b0000, '0, '0, 4'b1111, 2'b01, {5'd0, 5'd5}, {32'd0, 32'hDEAD_BEEF}, 1));
    vecs.push_back(v(1, 4'b0000, '0, '0, 4'b1111, 2'b00, '0, '0, 0));
    // X0 from src3 retires silently, rr_ptr=1
    vecs.push_back(v(1, 4'b1000, '0, {32'h1234, 96'd0}, 4'b1111, 2'b00, '0, '0, 1));
    vecs.push_back(v(1, 4'b0000, '0, '0, 4'b1111, 2'b00, '0, '0, 0));
    // X0 consumes a port: src0 x0, src1 x9, src2 x10 at rr_ptr=0
    vecs.push_back(v(1, 4'b0111, {5'd0, 5'd10, 5'd9, 5'd0}, {32'h0, 32'h33, 32'h22, 32'h11}, 4'b1111, 2'b00, '0, '0, 1));
    vecs.push_back(v(1, 4'b0000, '0, '0, 4'b1011, 2'b10, {5'd9, 5'd0}, {32'h22, 32'h0}, 1));
    vecs.push_back(v(1, 4'b0000, '0, '0, 4'b1111, 2'b01, {5'd0, 5'd10}, {32'h0, 32'h33}, 1));
    vecs.push_back(v(1, 4'b0000, '0, '0, 4'b1111, 2'b00, '0, '0, 0));
    // Same-address conflict on x7 with rr_ptr=1 (src0 write moves pointer 3 -> 1)
    vecs.push_back(v(1, 4'b0001, {15'd0, 5'd6}, {96'd0, 32'h44}, 4'b1111, 2'b00, '0, '0, 1));
    vecs.push_back(v(1, 4'b0110, {5'd0, 5'd7, 5'd7, 5'd0}, {32'h0, 32'h66, 32'h55, 32'h0}, 4'b1111, 2'b01, {5'd0, 5'd6}, {32'd0, 32'h44}, 1));
    vecs.push_back(v(1, 4'b0000, '0, '0, 4'b1011, 2'b01, {5'd0, 5'd7}, {32'd0, 32'h55}, 1));
    vecs.push_back(v(1, 4'b0000, '0, '0, 4'b1111, 2'b01, {5'd0, 5'd7}, {32'd0, 32'h66}, 1));
    vecs.push_back(v(1, 4'b0000, '0, '0, 4'b1111, 2'b00, '0, '0, 0));
    // Clock enable low for 3 cycles with two entries pending, rr_ptr=3
    vecs.push_back(v(1, 4'b0011, {10'd0, 5'd13, 5'd12}, {64'd0, 32'h88, 32'h77}, 4'b1111, 2'b00, '0, '0, 1));
    vecs.push_back(v(0, 4'b0011, {10'd0, 5'd13, 5'd12}, {64'd0, 32'hAA, 32'h99}, 4'b0000, 2'b00, '0, '0, 1));
    vecs.push_back(v(0, 4'b0011, {10'd0, 5'd13, 5'd12}, {64'd0, 32'hAA, 32'h99}, 4'b0000, 2'b00, '0, '0, 1));
    vecs.push_back(v(0, 4'b0011, {10'd0, 5'd13, 5'd12}, {64'd0, 32'hAA, 32'h99}, 4'b0000, 2'b00, '0, '0, 1));
    vecs.push_back(v(1, 4'b0000, '0, '0, 4'b1111, 2'b11, {5'd13, 5'd12}, {32'h88, 32'h77}, 1));
    vecs.push_back(v(0, 4'b0000, '0, '0, 4'b0000, 2'b00, '0, '0, 0));

    rst = 1'b1; en = 1'b1; valid = '0; addr = '0; data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset we", 32'(we), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset waddr", 32'(waddr), 32'd0);
    rst = 1'b0;
    #1;
    check("post-reset ready", 32'(ready), 32'hF);

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; valid = vecs[i].valid; addr = vecs[i].addr; data = vecs[i].data;
      #1;
      check($sformatf("v%0d ready", i), 32'(ready), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      check($sformatf("v%0d we", i), 32'(we), 32'(vecs[i].exp_we));
      for (int k = 0; k < 2; k++) begin
        if (vecs[i].exp_we[k]) begin
          check($sformatf("v%0d addr%0d", i, k), 32'(waddr[k*5 +: 5]), 32'(vecs[i].exp_addr[k]));
          check($sformatf("v%0d data%0d", i, k), wdata[k*32 +: 32], vecs[i].exp_data[k]);
        end
      end
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
    end

    // Asynchronous reset mid-cycle discards a live write and a pending entry
    en = 1'b1; valid = 4'b0001; addr = {15'd0, 5'd5}; data = {96'd0, 32'h5555_0005};
    @(posedge clk); #1;
    valid = 4'b0010; addr = {10'd0, 5'd6, 5'd0}; data = {64'd0, 32'h6666_0006, 32'd0};
    @(posedge clk); #1;
    valid = '0;
    check("pre-reset we", 32'(we), 32'h1);
    check("pre-reset addr0", 32'(waddr[4:0]), 32'd5);
    check("pre-reset busy", 32'(busy), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("async reset we", 32'(we), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("async release ready", 32'(ready), 32'hF);
    @(posedge clk); #1;
    check("discarded entry we", 32'(we), 32'd0);
    check("discarded entry busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
